// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// cache_mem_arbiter: shares one line-wide memory port between the I-cache and
// D-cache miss paths with round-robin arbitration and saturating grant counters.
module cache_mem_arbiter #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              last_grant,
  output logic [CNT_W-1:0]  i_grant_count,
  output logic [CNT_W-1:0]  d_grant_count
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  logic   i_req;
  logic   d_req;
  logic   pick_d;

  assign i_req  = i_read | i_write;
  assign d_req  = d_read | d_write;
  // On conflict, last_grant names the side served last, so the other side wins.
  assign pick_d = d_req & (~i_req | ~last_grant);

  assign i_resp  = (state == SERVE_I) & pmem_resp;
  assign d_resp  = (state == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pmem_read     <= 1'b0;
      pmem_write    <= 1'b0;
      pmem_address  <= '0;
      pmem_wdata    <= '0;
      last_grant    <= 1'b0;
      i_grant_count <= '0;
      d_grant_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state        <= SERVE_D;
            pmem_address <= d_address & LINE_MASK;
            pmem_wdata   <= d_wdata;
            pmem_write   <= d_write;
            pmem_read    <= d_read & ~d_write;
            last_grant   <= 1'b1;
            if (d_grant_count != CNT_MAX) d_grant_count <= d_grant_count + CNT_ONE;
          end else if (i_req) begin
            state        <= SERVE_I;
            pmem_address <= i_address & LINE_MASK;
            pmem_wdata   <= i_wdata;
            pmem_write   <= i_write;
            pmem_read    <= i_read & ~i_write;
            last_grant   <= 1'b0;
            if (i_grant_count != CNT_MAX) i_grant_count <= i_grant_count + CNT_ONE;
          end
        end
        SERVE_I, SERVE_D: begin
          // Address and write data are left as-is after completion.
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// tb_cache_mem_arbiter: table vectors, directed corner sequences and a
// randomized run checked against a transaction-level reference model.
module tb_cache_mem_arbiter;

  localparam int LB = 16;  // bytes per 128-bit line

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_read, i_write, d_read, d_write, pmem_resp;
  logic [15:0]  i_address, d_address;
  logic [127:0] i_wdata, d_wdata, pmem_rdata;

  logic [127:0] i_rdata, d_rdata, pmem_wdata;
  logic         i_resp, d_resp, pmem_read, pmem_write, last_grant;
  logic [15:0]  pmem_address, i_grant_count, d_grant_count;

  logic [127:0] s_i_rdata, s_d_rdata, s_pmem_wdata;
  logic         s_i_resp, s_d_resp, s_pmem_read, s_pmem_write, s_last_grant;
  logic [15:0]  s_pmem_address;
  logic [1:0]   s_i_grant_count, s_d_grant_count;

  int tests = 0;
  int fails = 0;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .last_grant(last_grant), .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
  );

  cache_mem_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_rdata(s_i_rdata), .i_resp(s_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(s_d_rdata), .d_resp(s_d_resp),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .pmem_address(s_pmem_address),
    .pmem_wdata(s_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .last_grant(s_last_grant), .i_grant_count(s_i_grant_count), .d_grant_count(s_d_grant_count)
  );

  always #5 clk = ~clk;

  // Reference model: who is being served (0 none, 1 I, 2 D) and what was granted.
  int           m_serv, m_icnt, m_dcnt;
  bit           m_rd, m_wr, m_last;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_serv = 0; m_icnt = 0; m_dcnt = 0;
    m_rd = 0; m_wr = 0; m_last = 0;
    m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_edge();
    bit ir, dr;
    ir = i_read | i_write;
    dr = d_read | d_write;
    if (rst) model_reset();
    else if (m_serv == 0) begin
      if (dr && (!ir || !m_last)) begin
        m_serv = 2; m_last = 1; m_dcnt++;
        m_addr = d_address - (d_address % LB); m_wdata = d_wdata;
        m_wr = d_write; m_rd = d_read && !d_write;
      end else if (ir) begin
        m_serv = 1; m_last = 0; m_icnt++;
        m_addr = i_address - (i_address % LB); m_wdata = i_wdata;
        m_wr = i_write; m_rd = i_read && !i_write;
      end
    end else if (pmem_resp) begin
      m_serv = 0; m_rd = 0; m_wr = 0;
    end
  endtask

  task automatic check_comb();
    chk("i_resp", i_resp, (m_serv == 1) && pmem_resp);
    chk("d_resp", d_resp, (m_serv == 2) && pmem_resp);
    chk("i_rdata", i_rdata, pmem_rdata);
    chk("d_rdata", d_rdata, pmem_rdata);
    chk("sat_i_resp", s_i_resp, (m_serv == 1) && pmem_resp);
    chk("sat_d_resp", s_d_resp, (m_serv == 2) && pmem_resp);
    chk("sat_i_rdata", s_i_rdata, pmem_rdata);
    chk("sat_d_rdata", s_d_rdata, pmem_rdata);
  endtask

  task automatic check_reg();
    chk("pmem_read", pmem_read, m_rd);
    chk("pmem_write", pmem_write, m_wr);
    chk("pmem_address", pmem_address, m_addr);
    chk("pmem_wdata", pmem_wdata, m_wdata);
    chk("last_grant", last_grant, m_last);
    chk("i_grant_count", i_grant_count, sat(m_icnt, 65535));
    chk("d_grant_count", d_grant_count, sat(m_dcnt, 65535));
    chk("sat_pmem_read", s_pmem_read, m_rd);
    chk("sat_pmem_write", s_pmem_write, m_wr);
    chk("sat_pmem_address", s_pmem_address, m_addr);
    chk("sat_pmem_wdata", s_pmem_wdata, m_wdata);
    chk("sat_last_grant", s_last_grant, m_last);
    chk("sat_i_grant_count", s_i_grant_count, sat(m_icnt, 3));
    chk("sat_d_grant_count", s_d_grant_count, sat(m_dcnt, 3));
  endtask

  // Inputs are set just after a falling edge; one call covers one clock cycle.
  task automatic step();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_reg();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; i_wdata = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    pmem_resp = 0;
    rst = 1;
    #1;
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_i_count", i_grant_count, 16'd0);
    chk("rst_d_count", d_grant_count, 16'd0);
    chk("rst_last_grant", last_grant, 1'b0);
    model_reset();
    step();
    rst = 0;
    step();
  endtask

  typedef struct {
    logic ir, iw, dr, dw;
    logic [15:0] ia, da;
    logic [127:0] iwd, dwd;
    logic e_rd, e_wr, e_last, e_d;
    logic [15:0] e_addr;
    logic [127:0] e_wdata;
  } vec_t;

  vec_t tbl[7];
  int   sat_exp[5] = '{1, 2, 3, 3, 3};
  bit   ip, dp, er_i, er_d;

  initial begin
    clear_inputs();
    pmem_resp = 0;
    pmem_rdata = '0;
    tbl[0] = '{1,0,0,0, 16'h1236, 16'h0000, 128'h11, 128'h0,  1,0,0,0, 16'h1230, 128'h11};
    tbl[1] = '{0,0,1,0, 16'h0000, 16'h2ABF, 128'h0,  128'h22, 1,0,1,1, 16'h2AB0, 128'h22};
    tbl[2] = '{1,0,1,0, 16'h3001, 16'h4002, 128'h33, 128'h44, 1,0,0,0, 16'h3000, 128'h33};
    tbl[3] = '{0,1,0,1, 16'h500F, 16'h6010, 128'h55, 128'h66, 0,1,1,1, 16'h6010, 128'h66};
    tbl[4] = '{0,0,1,1, 16'h0000, 16'h7777, 128'h0,  128'h77, 0,1,1,1, 16'h7770, 128'h77};
    tbl[5] = '{1,1,1,0, 16'h8888, 16'h9999, 128'h88, 128'h99, 0,1,0,0, 16'h8880, 128'h88};
    tbl[6] = '{0,0,0,0, 16'h0000, 16'h0000, 128'h0,  128'h0,  0,0,0,0, 16'h8880, 128'h88};
    @(negedge clk);

    // Table-driven grant decisions, each as a complete transaction.
    do_reset();
    for (int v = 0; v < 7; v++) begin
      i_read = tbl[v].ir; i_write = tbl[v].iw; d_read = tbl[v].dr; d_write = tbl[v].dw;
      i_address = tbl[v].ia; d_address = tbl[v].da; i_wdata = tbl[v].iwd; d_wdata = tbl[v].dwd;
      step();
      chk("tbl_rd", pmem_read, tbl[v].e_rd);
      chk("tbl_wr", pmem_write, tbl[v].e_wr);
      chk("tbl_last", last_grant, tbl[v].e_last);
      chk("tbl_addr", pmem_address, tbl[v].e_addr);
      chk("tbl_wdata", pmem_wdata, tbl[v].e_wdata);
      if (tbl[v].e_rd || tbl[v].e_wr) begin
        pmem_resp = 1; pmem_rdata = {4{$urandom}};
        #1;
        chk("tbl_i_resp", i_resp, !tbl[v].e_d);
        chk("tbl_d_resp", d_resp, tbl[v].e_d);
        step();
        clear_inputs(); pmem_resp = 0;
      end
      step();
    end

    // Single read with 3-cycle memory latency, then a stray response in IDLE.
    do_reset();
    i_read = 1; i_address = 16'h1236;
    #1 chk("sr_pre_rd", pmem_read, 1'b0);
    step();
    chk("sr_rd", pmem_read, 1'b1);
    chk("sr_addr", pmem_address, 16'h1230);
    step(); step(); step();
    pmem_resp = 1; pmem_rdata = {16{8'hA5}};
    #1;
    chk("sr_i_resp", i_resp, 1'b1);
    chk("sr_i_rdata", i_rdata, {16{8'hA5}});
    chk("sr_d_resp", d_resp, 1'b0);
    step();
    clear_inputs(); pmem_resp = 0;
    #1 chk("sr_i_resp_drop", i_resp, 1'b0);
    chk("sr_rd_drop", pmem_read, 1'b0);
    chk("sr_i_count", i_grant_count, 16'd1);
    step();
    pmem_resp = 1; pmem_rdata = {4{$urandom}};
    #1;
    chk("stray_i_resp", i_resp, 1'b0);
    chk("stray_d_resp", d_resp, 1'b0);
    step();
    chk("stray_addr", pmem_address, 16'h1230);
    chk("stray_rd", pmem_read, 1'b0);
    chk("stray_wr", pmem_write, 1'b0);
    chk("stray_last", last_grant, 1'b0);
    chk("stray_i_count", i_grant_count, 16'd1);
    pmem_resp = 0;
    step();

    // Simultaneous requests after reset: D first, I after the IDLE cycle.
    do_reset();
    i_read = 1; i_address = 16'h0100;
    d_write = 1; d_address = 16'h4000; d_wdata = 128'h1;
    step();
    chk("sim_wr", pmem_write, 1'b1);
    chk("sim_wdata", pmem_wdata, 128'h1);
    chk("sim_last_d", last_grant, 1'b1);
    step();
    pmem_resp = 1;
    #1 chk("sim_d_resp", d_resp, 1'b1);
    chk("sim_i_resp", i_resp, 1'b0);
    step();
    d_write = 0; pmem_resp = 0;
    #1 chk("sim_idle_rd", pmem_read, 1'b0);
    step();
    chk("sim_i_rd", pmem_read, 1'b1);
    chk("sim_i_addr", pmem_address, 16'h0100);
    chk("sim_last_i", last_grant, 1'b0);
    pmem_resp = 1;
    step();
    clear_inputs(); pmem_resp = 0;
    step();

    // Continuous contention: grants alternate D,I,D,I,...
    do_reset();
    i_read = 1; i_address = 16'h0010;
    d_read = 1; d_address = 16'h0020;
    for (int t = 0; t < 10; t++) begin
      step();
      chk("ct_last", last_grant, (t % 2) == 0);
      chk("ct_addr", pmem_address, ((t % 2) == 0) ? 16'h0020 : 16'h0010);
      step();
      pmem_resp = 1;
      step();
      pmem_resp = 0;
    end
    clear_inputs();
    chk("ct_i_count", i_grant_count, 16'd5);
    chk("ct_d_count", d_grant_count, 16'd5);
    step();

    // Reset in the middle of an I-cache transaction.
    do_reset();
    i_read = 1; i_address = 16'h0ABC;
    step(); step();
    rst = 1; i_read = 0;
    #1;
    chk("mid_rd", pmem_read, 1'b0);
    chk("mid_wr", pmem_write, 1'b0);
    chk("mid_i_count", i_grant_count, 16'd0);
    chk("mid_addr", pmem_address, 16'd0);
    model_reset();
    step();
    rst = 0; pmem_resp = 1;
    #1 chk("mid_i_resp", i_resp, 1'b0);
    step();
    pmem_resp = 0;
    step();
    chk("mid_rd_after", pmem_read, 1'b0);

    // Saturation of a 2-bit counter.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      i_read = 1; i_address = 16'(k * 16);
      step();
      chk("sat_seq", s_i_grant_count, sat_exp[k]);
      pmem_resp = 1;
      step();
      i_read = 0; pmem_resp = 0;
      step();
    end

    // Randomized traffic against the reference model.
    do_reset();
    ip = 0; dp = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ip) begin
        if ($urandom_range(0, 1) == 1) begin
          ip = 1;
          i_write = 1'($urandom_range(0, 1));
          i_read = i_write ? 1'($urandom_range(0, 1)) : 1'b1;
          i_address = 16'($urandom);
          i_wdata = {4{$urandom}};
        end else begin
          i_read = 0; i_write = 0;
        end
      end
      if (!dp) begin
        if ($urandom_range(0, 1) == 1) begin
          dp = 1;
          d_write = 1'($urandom_range(0, 1));
          d_read = d_write ? 1'($urandom_range(0, 1)) : 1'b1;
          d_address = 16'($urandom);
          d_wdata = {4{$urandom}};
        end else begin
          d_read = 0; d_write = 0;
        end
      end
      pmem_rdata = {4{$urandom}};
      pmem_resp = (m_serv != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      er_i = (m_serv == 1) && pmem_resp;
      er_d = (m_serv == 2) && pmem_resp;
      step();
      if (er_i) ip = 0;
      if (er_d) dp = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
